// File: rtl/mem_write_sequencer_pkg.sv
// Shared types and helpers for the memory write sequencer.
// Holds the default widths, the fill state encoding and the 8-bit scramble map.
package mem_write_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    LAST = 2'd2
  } state_t;

  // Lossy bit map: the top two source bits are dropped, bits [4:3] appear twice.
  function automatic logic [7:0] scramble8(input logic [7:0] d);
    return {d[1:0], d[5:2], d[4:3]};
  endfunction

endpackage

// File: rtl/mem_write_sequencer.sv
// Streams bytes from a valid/ready source into a contiguous RAM address range,
// optionally scrambling each byte; every output except in_ready comes from a flop.
module mem_write_sequencer
  import mem_write_pkg::*;
#(
  parameter int ADDR_W = mem_write_pkg::ADDR_W,
  parameter int DATA_W = mem_write_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic              scramble_en,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;
  logic [ADDR_W-1:0] end_reg, end_next;
  logic              scr_reg, scr_next;
  logic              cs_next;
  logic [ADDR_W-1:0] addr_next;
  logic [DATA_W-1:0] data_next;
  logic              busy_next, done_next, err_next;
  logic [DATA_W-1:0] scr_data;

  // The scramble map only exists for bytes; other widths write data unchanged.
  generate
    if (DATA_W == 8) begin : gen_scr
      assign scr_data = scramble8(in_data);
    end else begin : gen_noscr
      assign scr_data = in_data;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    end_next   = end_reg;
    scr_next   = scr_reg;
    cs_next    = 1'b0;
    addr_next  = mem_addr;
    data_next  = mem_data;
    busy_next  = busy;
    done_next  = 1'b0;
    err_next   = 1'b0;
    in_ready   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (start_addr <= end_addr) begin
            ptr_next   = start_addr;
            end_next   = end_addr;
            scr_next   = scramble_en;
            state_next = FILL;
            busy_next  = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      FILL: begin
        in_ready = ~abort;
        if (abort) begin
          state_next = IDLE;
          busy_next  = 1'b0;
          err_next   = 1'b1;
        end else if (in_valid) begin
          cs_next   = 1'b1;
          addr_next = ptr_reg;
          data_next = scr_reg ? scr_data : in_data;
          // Pointer stops at end_addr so a fill ending at the top address never wraps.
          if (ptr_reg == end_reg) begin
            state_next = LAST;
          end else begin
            ptr_next = ptr_reg + 1'b1;
          end
        end
      end
      LAST: begin
        state_next = IDLE;
        busy_next  = 1'b0;
        done_next  = 1'b1;
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      end_reg   <= '0;
      scr_reg   <= 1'b0;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      end_reg   <= end_next;
      scr_reg   <= scr_next;
      mem_cs    <= cs_next;
      mem_we    <= cs_next;
      mem_addr  <= addr_next;
      mem_data  <= data_next;
      busy      <= busy_next;
      done      <= done_next;
      err       <= err_next;
    end
  end

endmodule
